kalman_scalar_fx: RTL and testbench

Parametrised fixed-point scalar Kalman filter for the lock-in power channel. It block-averages 2^LOG2_DECIM ADC samples from the AXI-stream input into one measurement, then runs one predict/update step per block. The step uses an external divider through a valid/ready handshake for the gain. It emits the state estimate and gain on an output strobe. It replaces the fixed-width, single-mode filter stage, with a proper sequencer, saturation, runtime coefficients and soft re-initialisation.

---
 rtl/kalman_scalar_fx.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_kalman_scalar_fx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kalman_scalar_fx.sv
// -----------------------------------------------------------------------------
// kalman_scalar_fx
//
// Fixed-point scalar Kalman filter for the lock-in power channel.
//
// ADC samples arrive on an AXI-stream style input that has no backpressure.
// The filter averages each block of 2^LOG2_DECIM samples into one
// measurement y. It then runs one predict/update step per block:
//
//   x_p = PHI*x              P_p = PHI*(PHI*P) + Q
//   K   = P_p / (P_p + R)    (external divider, clamped to [0, 1.0])
//   x   = x_p + K*(y - x_p)  P   = P_p - K*P_p   (floored at 0)
//
// All values are signed Q(DATA_W-FRAC_W).FRAC_W. Products are rounded half-up
// and saturated. Sums are formed one bit wider and then saturated.
//
// Ports
//   clk, rst           clock; synchronous active-low reset
//   enable             gates sample acceptance; when low the sequencer idles
//   init               one-cycle soft re-initialisation of x/P, aborts a step
//   s_tdata/s_tvalid   ADC sample stream, signed field in s_tdata[ADC_W-1:0]
//   cfg_phi/q/r        transition gain, process noise, measurement noise
//   div_num/div_den    dividend/divisor presented to the external divider
//   div_valid/ready    divider request handshake
//   div_quot/_valid    divider result (Q format) and its strobe
//   m_tdata/m_gain     state estimate and gain, held between result strobes
//   m_tvalid           one-cycle result strobe
//   busy               high whenever a step is in progress
//   overrun_cnt        saturating count of samples dropped while busy
//
// Parameter constraints: ADC_W-1 <= FRAC_W <= DATA_W-2, 0 <= LOG2_DECIM <= 16,
// P_INIT >= 0, TDATA_W >= ADC_W.
// -----------------------------------------------------------------------------
module kalman_scalar_fx #(
    parameter int                TDATA_W    = 32,
    parameter int                ADC_W      = 14,
    parameter int                DATA_W     = 32,
    parameter int                FRAC_W     = 24,
    parameter int                LOG2_DECIM = 10,
    parameter logic [DATA_W-1:0] X_INIT     = '0,
    parameter logic [DATA_W-1:0] P_INIT     = DATA_W'(1) << (FRAC_W - 4)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               init,
    input  logic [TDATA_W-1:0] s_tdata,
    input  logic               s_tvalid,
    input  logic [DATA_W-1:0]  cfg_phi,
    input  logic [DATA_W-1:0]  cfg_q,
    input  logic [DATA_W-1:0]  cfg_r,
    output logic [DATA_W-1:0]  div_num,
    output logic [DATA_W-1:0]  div_den,
    output logic               div_valid,
    input  logic               div_ready,
    input  logic [DATA_W-1:0]  div_quot,
    input  logic               div_quot_valid,
    output logic [DATA_W-1:0]  m_tdata,
    output logic [DATA_W-1:0]  m_gain,
    output logic               m_tvalid,
    output logic               busy,
    output logic [15:0]        overrun_cnt
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int ACC_W   = ADC_W + LOG2_DECIM;    // block sum never overflows
    localparam int CNT_W   = LOG2_DECIM + 1;        // keeps width >= 1 when LOG2_DECIM=0
    localparam int PW      = 2 * DATA_W;            // full product width
    localparam int Y_SHIFT = FRAC_W - ADC_W + 1;    // ADC full scale -> +/-1.0

    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'((1 << LOG2_DECIM) - 1);
    localparam logic [DATA_W-1:0]        FX_ONE   = DATA_W'(1) << FRAC_W;
    localparam logic signed [DATA_W-1:0] FX_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] FX_MIN   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [PW-1:0]     RND_HALF = PW'(1) << (FRAC_W - 1);

    // -------------------------------------------------------------------------
    // Saturating fixed-point helpers
    // -------------------------------------------------------------------------

    // Clamp a full-width value into DATA_W. The value fits exactly when all
    // bits from the result sign bit upward agree.
    function automatic logic signed [DATA_W-1:0] sat_wide(input logic signed [PW-1:0] v);
        logic signed [DATA_W-1:0] r;
        if (v[PW-1:DATA_W-1] == {(PW-DATA_W+1){v[PW-1]}}) begin
            r = v[DATA_W-1:0];
        end else if (v[PW-1]) begin
            r = FX_MIN;
        end else begin
            r = FX_MAX;
        end
        return r;
    endfunction

    // Clamp a one-bit-wider sum back into DATA_W.
    function automatic logic signed [DATA_W-1:0] sat_narrow(input logic signed [DATA_W:0] v);
        logic signed [DATA_W-1:0] r;
        if (v[DATA_W] != v[DATA_W-1]) begin
            r = v[DATA_W] ? FX_MIN : FX_MAX;
        end else begin
            r = v[DATA_W-1:0];
        end
        return r;
    endfunction

    // Q-format multiply: full product, add half an LSB, arithmetic shift, saturate.
    function automatic logic signed [DATA_W-1:0] fx_mul(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
        logic signed [PW-1:0] prod;
        prod = PW'(a) * PW'(b);
        return sat_wide((prod + RND_HALF) >>> FRAC_W);
    endfunction

    function automatic logic signed [DATA_W-1:0] fx_add(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
        return sat_narrow({a[DATA_W-1], a} + {b[DATA_W-1], b});
    endfunction

    function automatic logic signed [DATA_W-1:0] fx_sub(input logic signed [DATA_W-1:0] a,
                                                        input logic signed [DATA_W-1:0] b);
        return sat_narrow({a[DATA_W-1], a} - {b[DATA_W-1], b});
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_ACC,
        S_PRED1,
        S_PRED2,
        S_DIV,
        S_WAIT,
        S_UPD,
        S_OUT
    } state_t;

    state_t                    state_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]          cnt_q;
    logic signed [DATA_W-1:0]  y_q;      // measurement of the current block
    logic signed [DATA_W-1:0]  x_q;      // state estimate
    logic signed [DATA_W-1:0]  p_q;      // error covariance
    logic signed [DATA_W-1:0]  phi_q;    // coefficients latched for the step
    logic signed [DATA_W-1:0]  q_q;
    logic signed [DATA_W-1:0]  r_q;
    logic signed [DATA_W-1:0]  xp_q;     // predicted state
    logic signed [DATA_W-1:0]  t_q;      // PHI*P intermediate
    logic signed [DATA_W-1:0]  pp_q;     // predicted covariance
    logic signed [DATA_W-1:0]  k_q;      // gain used for this step
    logic                      div_valid_q;
    logic [DATA_W-1:0]         div_num_q;
    logic [DATA_W-1:0]         div_den_q;
    logic [DATA_W-1:0]         m_tdata_q;
    logic [DATA_W-1:0]         m_gain_q;
    logic                      m_tvalid_q;
    logic [15:0]               overrun_q;

    // -------------------------------------------------------------------------
    // Datapath (next-state values)
    // -------------------------------------------------------------------------
    logic signed [ADC_W-1:0]   smp_d;
    logic signed [ACC_W-1:0]   acc_d;
    logic signed [ADC_W-1:0]   mean_d;
    logic signed [DATA_W-1:0]  y_d;
    logic signed [DATA_W-1:0]  xp_d;
    logic signed [DATA_W-1:0]  t_d;
    logic signed [DATA_W-1:0]  pp_d;
    logic signed [DATA_W-1:0]  den_d;
    logic                      den_pos_d;
    logic signed [DATA_W-1:0]  k_d;
    logic signed [DATA_W-1:0]  x_d;
    logic signed [DATA_W-1:0]  p_upd_d;
    logic signed [DATA_W-1:0]  p_d;

    always_comb begin
        smp_d  = s_tdata[ADC_W-1:0];
        acc_d  = acc_q + ACC_W'(smp_d);
        // Dropping the low LOG2_DECIM bits is an arithmetic floor divide. The
        // mean of ADC_W-bit samples always fits back into ADC_W bits.
        mean_d = acc_d[ACC_W-1:LOG2_DECIM];
        y_d    = DATA_W'(mean_d) <<< Y_SHIFT;

        // PRED1 uses the live coefficient inputs because it latches them in
        // the same cycle.
        xp_d   = fx_mul(cfg_phi, x_q);
        t_d    = fx_mul(cfg_phi, p_q);

        pp_d      = fx_add(fx_mul(phi_q, t_q), q_q);
        den_d     = fx_add(pp_d, r_q);
        den_pos_d = !den_d[DATA_W-1] && (den_d != '0);

        // The gain is a ratio of covariances, so it must lie in [0, 1.0].
        if (div_quot[DATA_W-1]) begin
            k_d = '0;
        end else if (div_quot > FX_ONE) begin
            k_d = FX_ONE;
        end else begin
            k_d = div_quot;
        end

        x_d     = fx_add(xp_q, fx_mul(k_q, fx_sub(y_q, xp_q)));
        p_upd_d = fx_sub(pp_q, fx_mul(k_q, pp_q));
        p_d     = p_upd_d[DATA_W-1] ? '0 : p_upd_d;
    end

    // -------------------------------------------------------------------------
    // Sequencer with registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            y_q         <= '0;
            x_q         <= X_INIT;
            p_q         <= P_INIT;
            phi_q       <= '0;
            q_q         <= '0;
            r_q         <= '0;
            xp_q        <= '0;
            t_q         <= '0;
            pp_q        <= '0;
            k_q         <= '0;
            div_valid_q <= 1'b0;
            div_num_q   <= '0;
            div_den_q   <= '0;
            m_tdata_q   <= X_INIT;
            m_gain_q    <= '0;
            m_tvalid_q  <= 1'b0;
            overrun_q   <= '0;
        end else begin
            m_tvalid_q <= 1'b0;

            // Without backpressure, any sample that arrives during a step is lost.
            if (s_tvalid && enable && (state_q != S_ACC) && (overrun_q != 16'hFFFF)) begin
                overrun_q <= overrun_q + 16'd1;
            end

            if (init) begin
                // A soft re-init outranks every transition. A quotient that
                // arrives later is ignored because the sequencer is back in ACC.
                state_q     <= S_ACC;
                acc_q       <= '0;
                cnt_q       <= '0;
                x_q         <= X_INIT;
                p_q         <= P_INIT;
                div_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    S_ACC: begin
                        if (s_tvalid && enable) begin
                            acc_q <= acc_d;
                            cnt_q <= cnt_q + CNT_W'(1);
                            if (cnt_q == CNT_LAST) begin
                                y_q     <= y_d;
                                state_q <= S_PRED1;
                            end
                        end
                    end

                    S_PRED1: begin
                        phi_q   <= cfg_phi;
                        q_q     <= cfg_q;
                        r_q     <= cfg_r;
                        xp_q    <= xp_d;
                        t_q     <= t_d;
                        state_q <= S_PRED2;
                    end

                    S_PRED2: begin
                        pp_q <= pp_d;
                        if (den_pos_d) begin
                            div_num_q   <= pp_d;
                            div_den_q   <= den_d;
                            div_valid_q <= 1'b1;
                            state_q     <= S_DIV;
                        end else begin
                            // A non-positive innovation variance means there is
                            // nothing to trust in the measurement: skip the divide.
                            k_q     <= '0;
                            state_q <= S_UPD;
                        end
                    end

                    S_DIV: begin
                        // div_quot_valid is deliberately ignored until the
                        // request has been accepted.
                        if (div_ready) begin
                            div_valid_q <= 1'b0;
                            state_q     <= S_WAIT;
                        end
                    end

                    S_WAIT: begin
                        if (div_quot_valid) begin
                            k_q     <= k_d;
                            state_q <= S_UPD;
                        end
                    end

                    S_UPD: begin
                        x_q        <= x_d;
                        p_q        <= p_d;
                        m_tdata_q  <= x_d;
                        m_gain_q   <= k_q;
                        m_tvalid_q <= 1'b1;
                        state_q    <= S_OUT;
                    end

                    S_OUT: begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_ACC;
                    end

                    default: begin
                        state_q <= S_ACC;
                    end
                endcase
            end
        end
    end

    // Bits above the ADC field carry no information for this channel.
    generate
        if (TDATA_W > ADC_W) begin : g_tdata_hi
            logic unused_tdata_hi;
            assign unused_tdata_hi = ^s_tdata[TDATA_W-1:ADC_W];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign div_num     = div_num_q;
    assign div_den     = div_den_q;
    assign div_valid   = div_valid_q;
    assign m_tdata     = m_tdata_q;
    assign m_gain      = m_gain_q;
    assign m_tvalid    = m_tvalid_q;
    assign busy        = (state_q != S_ACC);
    assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_kalman_scalar_fx.sv
// -----------------------------------------------------------------------------
// Directed bench for kalman_scalar_fx. It uses LOG2_DECIM=2, FRAC_W=24,
// X_INIT=0 and P_INIT=0x0040_0000. Every expected value below is worked out
// by hand from the filter equations.
// -----------------------------------------------------------------------------
module tb_kalman_scalar_fx;

    localparam int TDATA_W    = 32;
    localparam int ADC_W      = 14;
    localparam int DATA_W     = 32;
    localparam int FRAC_W     = 24;
    localparam int LOG2_DECIM = 2;
    localparam logic [31:0] X_INIT_TB = 32'h0000_0000;
    localparam logic [31:0] P_INIT_TB = 32'h0040_0000;
    localparam logic [31:0] ONE       = 32'h0100_0000;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic               init;
    logic [TDATA_W-1:0] s_tdata;
    logic               s_tvalid;
    logic [DATA_W-1:0]  cfg_phi;
    logic [DATA_W-1:0]  cfg_q;
    logic [DATA_W-1:0]  cfg_r;
    logic [DATA_W-1:0]  div_num;
    logic [DATA_W-1:0]  div_den;
    logic               div_valid;
    logic               div_ready;
    logic [DATA_W-1:0]  div_quot;
    logic               div_quot_valid;
    logic [DATA_W-1:0]  m_tdata;
    logic [DATA_W-1:0]  m_gain;
    logic               m_tvalid;
    logic               busy;
    logic [15:0]        overrun_cnt;

    kalman_scalar_fx #(
        .TDATA_W    (TDATA_W),
        .ADC_W      (ADC_W),
        .DATA_W     (DATA_W),
        .FRAC_W     (FRAC_W),
        .LOG2_DECIM (LOG2_DECIM),
        .X_INIT     (X_INIT_TB),
        .P_INIT     (P_INIT_TB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .init           (init),
        .s_tdata        (s_tdata),
        .s_tvalid       (s_tvalid),
        .cfg_phi        (cfg_phi),
        .cfg_q          (cfg_q),
        .cfg_r          (cfg_r),
        .div_num        (div_num),
        .div_den        (div_den),
        .div_valid      (div_valid),
        .div_ready      (div_ready),
        .div_quot       (div_quot),
        .div_quot_valid (div_quot_valid),
        .m_tdata        (m_tdata),
        .m_gain         (m_gain),
        .m_tvalid       (m_tvalid),
        .busy           (busy),
        .overrun_cnt    (overrun_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Feed one block of four identical samples. On return the DUT is in PRED1.
    // With hold set, s_tvalid stays high so that busy cycles drop samples.
    task automatic send_block(input string name, input logic [31:0] w, input bit hold);
        for (int i = 0; i < 4; i++) begin
            s_tdata  = w;
            s_tvalid = 1'b1;
            step();
            chk({name, "_busy_acc"}, 32'(busy), (i == 3) ? 32'd1 : 32'd0);
        end
        if (!hold) s_tvalid = 1'b0;
    endtask

    // One step through the divider path. n_wait cycles of div_ready=0 are
    // inserted in DIV; a bogus quotient is pulsed there when n_wait > 2.
    task automatic div_block(input string name, input logic [31:0] smp, input int n_wait,
                             input logic [31:0] quot, input logic [31:0] exp_num,
                             input logic [31:0] exp_den, input logic [31:0] exp_x,
                             input logic [31:0] exp_k, input bit hold);
        send_block(name, smp, hold);
        chk({name, "_p1_tvalid"}, 32'(m_tvalid), 32'd0);
        step();                                            // PRED2
        chk({name, "_p2_divv"}, 32'(div_valid), 32'd0);
        step();                                            // DIV
        chk({name, "_div_valid"}, 32'(div_valid), 32'd1);
        chk({name, "_div_num"}, div_num, exp_num);
        chk({name, "_div_den"}, div_den, exp_den);
        for (int i = 0; i < n_wait; i++) begin
            div_ready = 1'b0;
            if (i == 2) begin
                div_quot_valid = 1'b1;
                div_quot       = 32'h0000_0001;
            end
            step();
            div_quot_valid = 1'b0;
            chk({name, "_hold_valid"}, 32'(div_valid), 32'd1);
            chk({name, "_hold_num"}, div_num, exp_num);
            chk({name, "_hold_den"}, div_den, exp_den);
            chk({name, "_hold_tvalid"}, 32'(m_tvalid), 32'd0);
        end
        div_ready = 1'b1;
        step();                                            // WAIT
        div_ready = 1'b0;
        chk({name, "_wait_divv"}, 32'(div_valid), 32'd0);
        div_quot_valid = 1'b1;
        div_quot       = quot;
        step();                                            // UPD
        div_quot_valid = 1'b0;
        chk({name, "_upd_tvalid"}, 32'(m_tvalid), 32'd0);
        step();                                            // OUT
        chk({name, "_out_tvalid"}, 32'(m_tvalid), 32'd1);
        chk({name, "_x"}, m_tdata, exp_x);
        chk({name, "_k"}, m_gain, exp_k);
        step();                                            // back in ACC
        if (hold) s_tvalid = 1'b0;
        chk({name, "_acc_tvalid"}, 32'(m_tvalid), 32'd0);
        chk({name, "_acc_busy"}, 32'(busy), 32'd0);
        chk({name, "_x_held"}, m_tdata, exp_x);
        $display("blk %s: x=0x%08h k=0x%08h ovr=%0d", name, m_tdata, m_gain, overrun_cnt);
    endtask

    // One step through the non-positive-denominator path. K must be 0 and the
    // divider must never be requested.
    task automatic zero_block(input string name, input logic [31:0] smp, input logic [31:0] exp_x);
        send_block(name, smp, 1'b0);
        step();                                            // PRED2
        chk({name, "_p2_divv"}, 32'(div_valid), 32'd0);
        step();                                            // UPD
        chk({name, "_upd_divv"}, 32'(div_valid), 32'd0);
        chk({name, "_upd_tvalid"}, 32'(m_tvalid), 32'd0);
        step();                                            // OUT
        chk({name, "_out_tvalid"}, 32'(m_tvalid), 32'd1);
        chk({name, "_out_divv"}, 32'(div_valid), 32'd0);
        chk({name, "_x"}, m_tdata, exp_x);
        chk({name, "_k"}, m_gain, 32'd0);
        step();
        chk({name, "_acc_tvalid"}, 32'(m_tvalid), 32'd0);
        $display("blk %s: x=0x%08h k=0x%08h ovr=%0d", name, m_tdata, m_gain, overrun_cnt);
    endtask

    task automatic pulse_init();
        init = 1'b1;
        step();
        init = 1'b0;
        chk("init_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        rst            = 1'b0;
        enable         = 1'b1;
        init           = 1'b0;
        s_tdata        = '0;
        s_tvalid       = 1'b0;
        cfg_phi        = ONE;
        cfg_q          = '0;
        cfg_r          = '0;
        div_ready      = 1'b0;
        div_quot       = '0;
        div_quot_valid = 1'b0;

        // Reset held for three cycles while samples toggle.
        for (int i = 0; i < 3; i++) begin
            s_tdata  = 32'h0000_1000;
            s_tvalid = (i % 2 == 0);
            step();
            chk("rst_tvalid", 32'(m_tvalid), 32'd0);
            chk("rst_divv", 32'(div_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_ovr", 32'(overrun_cnt), 32'd0);
            chk("rst_tdata", m_tdata, X_INIT_TB);
        end
        s_tvalid = 1'b0;
        rst      = 1'b1;
        step();

        // Samples with enable low are neither accumulated nor counted.
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_tdata  = 32'h0000_1FFF;
            s_tvalid = 1'b1;
            step();
        end
        s_tvalid = 1'b0;
        chk("en_low_busy", 32'(busy), 32'd0);
        chk("en_low_ovr", 32'(overrun_cnt), 32'd0);
        enable = 1'b1;

        // y=0.5, x=0, P=0.25, R=0 -> K=1.0, x=0.5, P=0.
        div_block("unity", 32'h0000_1000, 0, ONE, P_INIT_TB, P_INIT_TB,
                  32'h0080_0000, ONE, 1'b0);
        // P=0, Q=R=0 -> zero denominator, x unchanged.
        zero_block("zden", 32'h0000_1000, 32'h0080_0000);
        // PHI ~ 128: 0.5 -> 64.0, then saturates positive.
        cfg_phi = 32'h7FFF_FFFF;
        zero_block("phi_big1", 32'h0000_1000, 32'h4000_0000);
        zero_block("phi_big2", 32'h0000_1000, 32'h7FFF_FFFF);

        // Re-init, then a negative measurement with an over-range quotient
        // (2.0 clamps to 1.0). Upper tdata bits must be ignored.
        pulse_init();
        cfg_phi = ONE;
        div_block("neg", 32'hABCD_3000, 0, 32'h0200_0000, P_INIT_TB, P_INIT_TB,
                  32'hFF80_0000, ONE, 1'b0);
        cfg_phi = 32'h7FFF_FFFF;
        zero_block("phi_neg1", 32'h0000_1000, 32'hC000_0001);
        zero_block("phi_neg2", 32'h0000_1000, 32'h8000_0000);

        // R=P_INIT, K=0.5 after a 10-cycle divider stall with samples streaming.
        pulse_init();
        cfg_phi = ONE;
        cfg_r   = P_INIT_TB;
        div_block("stall", 32'h0000_1000, 10, 32'h0080_0000, P_INIT_TB, 32'h0080_0000,
                  32'h0040_0000, 32'h0080_0000, 1'b1);
        chk("stall_ovr", 32'(overrun_cnt), 32'd16);

        // The divider request carries P=0.125 left by the previous update.
        // init in WAIT aborts the step and the late quotient is ignored.
        cfg_r = '0;
        send_block("abort", 32'h0000_1000, 1'b0);
        step();
        step();
        chk("abort_divv", 32'(div_valid), 32'd1);
        chk("abort_num", div_num, 32'h0020_0000);
        chk("abort_den", div_den, 32'h0020_0000);
        div_ready = 1'b1;
        step();
        div_ready = 1'b0;
        chk("abort_wait_busy", 32'(busy), 32'd1);
        pulse_init();
        chk("abort_divv_off", 32'(div_valid), 32'd0);
        div_quot_valid = 1'b1;
        div_quot       = ONE;
        step();
        div_quot_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("abort_tvalid", 32'(m_tvalid), 32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
            step();
        end
        chk("abort_tdata_held", m_tdata, 32'h0040_0000);
        $display("blk abort: x=0x%08h k=0x%08h ovr=%0d", m_tdata, m_gain, overrun_cnt);

        // x was reloaded to X_INIT and P to P_INIT; a negative quotient clamps
        // to K=0, so the output is X_INIT.
        div_block("post_init", 32'h0000_1000, 0, 32'hF000_0000, P_INIT_TB, P_INIT_TB,
                  X_INIT_TB, 32'd0, 1'b0);
        chk("post_init_ovr", 32'(overrun_cnt), 32'd16);

        // Reset while the divider request is pending.
        send_block("rst_hs", 32'h0000_1000, 1'b0);
        step();
        step();
        chk("rst_hs_divv_on", 32'(div_valid), 32'd1);
        rst = 1'b0;
        step();
        chk("rst_hs_divv", 32'(div_valid), 32'd0);
        chk("rst_hs_busy", 32'(busy), 32'd0);
        chk("rst_hs_ovr", 32'(overrun_cnt), 32'd0);
        chk("rst_hs_tdata", m_tdata, X_INIT_TB);
        rst = 1'b1;
        step();
        $display("blk rst_hs: divv=%0d busy=%0d ovr=%0d", div_valid, busy, overrun_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
